counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 85 ++++++++
 tb/tb_counter_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Down-counter controller with one-shot and periodic modes, hold/freeze and abort.
// Reset is synchronous and active-low; every output is a register.
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HELD = 2'b10
    } state_t;

    state_t           cur_state;
    logic [WIDTH-1:0] reload_reg;
    logic             mode_reg;

    assign state = cur_state;

    // abort outranks hold, and hold outranks the count/terminal action; leaving
    // HELD with hold low performs the RUN action on that same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state  <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            tc         <= 1'b0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start && !abort) begin
                        reload_reg <= load_val;
                        mode_reg   <= auto_reload;
                        count      <= load_val;
                        cur_state  <= RUN;
                        busy       <= 1'b1;
                    end
                end
                RUN, HELD: begin
                    if (abort) begin
                        cur_state <= IDLE;
                        count     <= '0;
                        busy      <= 1'b0;
                    end else if (hold) begin
                        cur_state <= HELD;
                        busy      <= 1'b1;
                    end else if (count != '0) begin
                        count     <= count - WIDTH'(1);
                        cur_state <= RUN;
                        busy      <= 1'b1;
                    end else begin
                        tc <= 1'b1;
                        if (mode_reg) begin
                            count     <= reload_reg;
                            cur_state <= RUN;
                            busy      <= 1'b1;
                        end else begin
                            cur_state <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] count;
    logic [1:0] state;
    logic       busy;
    logic       tc;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: "active" = a sequence is in progress, "frozen" = it is paused.
    bit m_active = 1'b0;
    bit m_frozen = 1'b0;
    bit m_mode = 1'b0;
    bit m_tc = 1'b0;
    int m_count = 0;
    int m_reload = 0;

    counter_ctrl #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .hold(hold),
        .auto_reload(auto_reload),
        .load_val(load_val),
        .count(count),
        .state(state),
        .busy(busy),
        .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one set of inputs for exactly one rising edge, then return just after it.
    task automatic applyStimulus(input logic rst_n, input logic st, input logic ab,
                                 input logic hd, input logic ar, input logic [7:0] lv);
        @(negedge clk);
        reset = rst_n;
        start = st;
        abort = ab;
        hold = hd;
        auto_reload = ar;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    always @(posedge clk) begin
        m_tc = 1'b0;
        if (!reset) begin
            m_active = 1'b0;
            m_frozen = 1'b0;
            m_mode = 1'b0;
            m_count = 0;
            m_reload = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_reload = int'(load_val);
                m_mode = auto_reload;
                m_count = int'(load_val);
                m_active = 1'b1;
                m_frozen = 1'b0;
            end
        end else if (abort) begin
            m_active = 1'b0;
            m_frozen = 1'b0;
            m_count = 0;
        end else if (hold) begin
            m_frozen = 1'b1;
        end else begin
            m_frozen = 1'b0;
            if (m_count > 0) begin
                m_count = m_count - 1;
            end else begin
                m_tc = 1'b1;
                if (m_mode) m_count = m_reload;
                else m_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cmp_count", int'(count), m_count);
            checkOutput("cmp_state", int'(state), m_active ? (m_frozen ? 2 : 1) : 0);
            checkOutput("cmp_busy", int'(busy), int'(m_active));
            checkOutput("cmp_tc", int'(tc), int'(m_tc));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit got;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cmp_en = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd5);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_tc", int'(tc), 0);

        $display("[TB] one-shot load 3");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        checkOutput("os_start_count", int'(count), 3);
        checkOutput("os_start_state", int'(state), 1);
        checkOutput("os_start_busy", int'(busy), 1);
        for (int i = 2; i >= 0; i--) begin
            idleStep();
            checkOutput("os_count", int'(count), i);
            checkOutput("os_tc_early", int'(tc), 0);
        end
        idleStep();
        checkOutput("os_tc", int'(tc), 1);
        checkOutput("os_end_state", int'(state), 0);
        checkOutput("os_end_busy", int'(busy), 0);
        idleStep();
        checkOutput("os_tc_single", int'(tc), 0);

        $display("[TB] periodic load 2, start/load changes while running");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
        checkOutput("per_start_count", int'(count), 2);
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7);
            checkOutput("per_count1", int'(count), 1);
            checkOutput("per_tc1", int'(tc), 0);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7);
            checkOutput("per_count0", int'(count), 0);
            checkOutput("per_tc0", int'(tc), 0);
            idleStep();
            checkOutput("per_reload", int'(count), 2);
            checkOutput("per_tc", int'(tc), 1);
            checkOutput("per_state", int'(state), 1);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("per_abort_state", int'(state), 0);

        $display("[TB] hold load 5");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        idleStep();
        idleStep();
        checkOutput("hold_pre_count", int'(count), 3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            checkOutput("hold_state", int'(state), 2);
            checkOutput("hold_count", int'(count), 3);
            checkOutput("hold_tc", int'(tc), 0);
        end
        n = 6;
        got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            idleStep();
            n++;
            if (tc) got = 1'b1;
        end
        checkOutput("hold_tc_latency", got ? n : 0, 10);

        $display("[TB] abort with hold, start+abort in idle");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
        idleStep();
        idleStep();
        checkOutput("abort_pre_count", int'(count), 4);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("abort_state", int'(state), 0);
        checkOutput("abort_count", int'(count), 0);
        checkOutput("abort_tc", int'(tc), 0);
        checkOutput("abort_busy", int'(busy), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
        checkOutput("start_abort_state", int'(state), 0);
        checkOutput("start_abort_count", int'(count), 0);

        $display("[TB] reset mid-run, then load 0");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
        idleStep();
        idleStep();
        idleStep();
        checkOutput("mid_pre_count", int'(count), 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("mid_rst_count", int'(count), 0);
        checkOutput("mid_rst_state", int'(state), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_tc", int'(tc), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("zero_tc_early", int'(tc), 0);
        idleStep();
        checkOutput("zero_tc", int'(tc), 1);
        checkOutput("zero_state", int'(state), 0);

        $display("[TB] load 255");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
        checkOutput("big_count", int'(count), 255);
        n = 0;
        got = 1'b0;
        for (int i = 1; i <= 300 && !got; i++) begin
            idleStep();
            if (tc) begin
                got = 1'b1;
                n = i;
            end
        end
        checkOutput("big_tc_latency", n, 256);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 63) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 31) == 0,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12)));
        end
        idleStep();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
